// File: rtl/dsp_tag_alloc.sv
// Circular in-order ID allocator with retire reclaim and flush rollback. Grant and IDs are combinational; pointers update next cycle.
// Backpressure: a request is refused whole on stall, flush or insufficient free entries; retire is never blocked.
module dsp_tag_alloc #(
  parameter int DEPTH      = 128,
  parameter int LANES      = 4,
  parameter int RET_LANES  = 4,
  parameter int FLUSH_KEEP = 1,
  localparam int IDW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush_trap,
  input  logic                 i_flush_a_vld,
  input  logic [IDW-1:0]       i_flush_a_id,
  input  logic                 i_flush_b_vld,
  input  logic [IDW-1:0]       i_flush_b_id,
  input  logic                 i_stall,
  input  logic [LANES-1:0]     i_req_vld,
  output logic                 o_grant,
  output logic [LANES*IDW-1:0] o_id,
  output logic [IDW-1:0]       o_dsp_ptr,
  output logic [IDW-1:0]       o_ret_ptr,
  input  logic [RET_LANES-1:0] i_ret_vld,
  output logic [IDW-1:0]       o_free_cnt,
  output logic                 o_list_empty
);

  logic [IDW-1:0] dsp_ptr, ret_ptr, dsp_nxt, ret_nxt;
  logic [IDW-1:0] occ, free_cnt, sel_id;
  logic [IDW:0]   req_cnt, ret_cnt;
  logic           any_partial, any_flush;

  // Lap bit decides whether the low-bit compare is direct or inverted.
  function automatic logic older(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
    if (a[IDW-1] == b[IDW-1]) return a[IDW-2:0] < b[IDW-2:0];
    else                      return a[IDW-2:0] >= b[IDW-2:0];
  endfunction

  assign occ      = dsp_ptr - ret_ptr;
  assign free_cnt = IDW'(DEPTH) - occ;

  always_comb begin
    req_cnt = '0;
    o_id    = '0;
    for (int k = 0; k < LANES; k++) begin
      o_id[k*IDW +: IDW] = dsp_ptr + req_cnt[IDW-1:0];
      req_cnt = req_cnt + (IDW+1)'(i_req_vld[k]);
    end
  end

  always_comb begin
    ret_cnt = '0;
    for (int k = 0; k < RET_LANES; k++) ret_cnt = ret_cnt + (IDW+1)'(i_ret_vld[k]);
  end

  assign any_partial = i_flush_a_vld | i_flush_b_vld;
  assign any_flush   = i_flush_trap | any_partial;

  always_comb begin
    sel_id = i_flush_a_id;
    if (i_flush_a_vld && i_flush_b_vld)
      sel_id = older(i_flush_a_id, i_flush_b_id) ? i_flush_a_id : i_flush_b_id;
    else if (i_flush_b_vld)
      sel_id = i_flush_b_id;
  end

  assign o_grant = (|i_req_vld) & ~i_stall & ~any_flush & ({1'b0, free_cnt} >= req_cnt);
  assign ret_nxt = ret_ptr + ret_cnt[IDW-1:0];

  always_comb begin
    dsp_nxt = dsp_ptr;
    if (i_flush_trap)     dsp_nxt = ret_nxt;
    else if (any_partial) dsp_nxt = sel_id + IDW'(FLUSH_KEEP);
    else if (o_grant)     dsp_nxt = dsp_ptr + req_cnt[IDW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dsp_ptr <= '0;
      ret_ptr <= '0;
    end else begin
      dsp_ptr <= dsp_nxt;
      ret_ptr <= ret_nxt;
    end
  end

  assign o_dsp_ptr    = dsp_ptr;
  assign o_ret_ptr    = ret_ptr;
  assign o_free_cnt   = free_cnt;
  assign o_list_empty = (free_cnt == '0);

  always @(posedge clk) begin
    if (!rst) begin
      assert ((i_ret_vld & (i_ret_vld + RET_LANES'(1))) == '0);
      assert (ret_cnt <= {1'b0, occ});
      if (i_flush_a_vld) assert (IDW'(i_flush_a_id - ret_ptr) < occ);
      if (i_flush_b_vld) assert (IDW'(i_flush_b_id - ret_ptr) < occ);
    end
  end

endmodule

// File: tb/tb_dsp_tag_alloc.sv
// Directed bench for dsp_tag_alloc at DEPTH=8, LANES=4; a FLUSH_KEEP=0 twin shares all inputs.
module tb_dsp_tag_alloc;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           trap = 1'b0, a_vld = 1'b0, b_vld = 1'b0, stall = 1'b0;
  logic [IDW-1:0] a_id = '0, b_id = '0;
  logic [3:0]     req = '0, ret = '0;

  logic           g0, g1, e0, e1;
  logic [4*IDW-1:0] id0, id1;
  logic [IDW-1:0] dp0, dp1, rp0, rp1, fc0, fc1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsp_tag_alloc #(.DEPTH(8), .LANES(4), .RET_LANES(4), .FLUSH_KEEP(1)) dut0 (
    .clk(clk), .rst(rst), .i_flush_trap(trap),
    .i_flush_a_vld(a_vld), .i_flush_a_id(a_id), .i_flush_b_vld(b_vld), .i_flush_b_id(b_id),
    .i_stall(stall), .i_req_vld(req), .o_grant(g0), .o_id(id0),
    .o_dsp_ptr(dp0), .o_ret_ptr(rp0), .i_ret_vld(ret), .o_free_cnt(fc0), .o_list_empty(e0));

  dsp_tag_alloc #(.DEPTH(8), .LANES(4), .RET_LANES(4), .FLUSH_KEEP(0)) dut1 (
    .clk(clk), .rst(rst), .i_flush_trap(trap),
    .i_flush_a_vld(a_vld), .i_flush_a_id(a_id), .i_flush_b_vld(b_vld), .i_flush_b_id(b_id),
    .i_stall(stall), .i_req_vld(req), .o_grant(g1), .o_id(id1),
    .o_dsp_ptr(dp1), .o_ret_ptr(rp1), .i_ret_vld(ret), .o_free_cnt(fc1), .o_list_empty(e1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ret = '0; trap = 1'b0; a_vld = 1'b0; b_vld = 1'b0; stall = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_dsp", dp0, 0);
    chk("rst_ret", rp0, 0);
    chk("rst_free", fc0, 8);
    chk("rst_empty", e0, 0);
    chk("rst_grant", g0, 0);
    req = 4'b1111; #1;
    chk("rst_id0", id0[0*IDW +: IDW], 0);
    chk("rst_id1", id0[1*IDW +: IDW], 1);
    chk("rst_id2", id0[2*IDW +: IDW], 2);
    chk("rst_id3", id0[3*IDW +: IDW], 3);

    // Sparse request, then stalled
    req = 4'b1011; #1;
    chk("sp_lane0", id0[0*IDW +: IDW], 0);
    chk("sp_lane1", id0[1*IDW +: IDW], 1);
    chk("sp_lane3", id0[3*IDW +: IDW], 2);
    chk("sp_grant", g0, 1);
    tick(); req = '0; #1;
    chk("sp_dsp", dp0, 3);
    chk("sp_free", fc0, 5);
    req = 4'b1011; stall = 1'b1; #1;
    chk("stall_grant", g0, 0);
    chk("stall_lane3", id0[3*IDW +: IDW], 5);
    tick(); req = '0; stall = 1'b0; #1;
    chk("stall_dsp", dp0, 3);

    // Fill to full
    req = 4'b1111; tick();
    req = 4'b0001; #1;
    chk("fill_grant", g0, 1);
    tick(); #1;
    chk("full_dsp", dp0, 8);
    chk("full_free", fc0, 0);
    chk("full_empty", e0, 1);
    chk("full_grant", g0, 0);
    tick();
    chk("full_dsp_hold", dp0, 8);
    req = '0; ret = 4'b0011; tick(); ret = '0; #1;
    chk("ret_ptr", rp0, 2);
    chk("ret_free", fc0, 2);
    chk("ret_empty", e0, 0);

    // Same-cycle retire does not help the grant
    req = 4'b1111; ret = 4'b0011; #1;
    chk("preret_grant", g0, 0);
    tick(); req = '0; ret = '0; #1;
    chk("preret_ret", rp0, 4);
    chk("preret_free", fc0, 4);
    req = 4'b1111; tick(); req = '0; #1;
    chk("lap_dsp", dp0, 12);
    chk("lap_free", fc0, 0);
    ret = 4'b1111; tick(); tick(); ret = '0;
    chk("lap_ret", rp0, 12);
    req = 4'b1111; #1;
    chk("wrap_id3", id0[3*IDW +: IDW], 15);
    tick(); req = '0; #1;
    chk("wrap_dsp", dp0, 0);
    chk("wrap_free", fc0, 4);

    // Dual flush, same lap
    do_reset();
    req = 4'b1111; tick();
    req = 4'b0111; tick();
    req = 4'b0001; a_vld = 1'b1; a_id = 4'd5; b_vld = 1'b1; b_id = 4'd3; #1;
    chk("df_pre_dsp", dp0, 7);
    chk("df_grant0", g0, 0);
    chk("df_grant1", g1, 0);
    tick(); req = '0; a_vld = 1'b0; b_vld = 1'b0; #1;
    chk("df_keep1_dsp", dp0, 4);
    chk("df_keep0_dsp", dp1, 3);

    // Dual flush across wrap
    do_reset();
    req = 4'b1111; tick(); tick();
    req = '0; ret = 4'b1111; tick();
    ret = 4'b0011; tick();
    ret = '0; req = 4'b0011; tick(); req = '0; #1;
    chk("xw_dsp", dp0, 10);
    chk("xw_ret", rp0, 6);
    chk("xw_free", fc0, 4);
    req = 4'b0001; a_vld = 1'b1; a_id = 4'b1001; b_vld = 1'b1; b_id = 4'b0111; #1;
    chk("xw_grant", g0, 0);
    tick(); req = '0; a_vld = 1'b0; b_vld = 1'b0; #1;
    chk("xw_keep1_dsp", dp0, 8);
    chk("xw_keep0_dsp", dp1, 7);

    // Trap with concurrent retire beats a partial flush
    do_reset();
    req = 4'b1111; tick();
    req = 4'b0011; tick();
    req = '0; ret = 4'b0011; tick(); #1;
    chk("tr_pre_dsp", dp0, 6);
    chk("tr_pre_ret", rp0, 2);
    ret = 4'b0011; trap = 1'b1; a_vld = 1'b1; a_id = 4'd2; req = 4'b1111; #1;
    chk("tr_grant", g0, 0);
    tick(); ret = '0; trap = 1'b0; a_vld = 1'b0; req = '0; #1;
    chk("tr_ret", rp0, 4);
    chk("tr_dsp0", dp0, 4);
    chk("tr_dsp1", dp1, 4);
    chk("tr_free", fc0, 8);

    // Allocation resumes, then reset overrides traffic
    req = 4'b0111; #1;
    chk("resume_grant", g0, 1);
    rst = 1'b1; ret = 4'b0001; trap = 1'b1; tick();
    rst = 1'b0; req = '0; ret = '0; trap = 1'b0; #1;
    chk("rov_dsp", dp0, 0);
    chk("rov_ret", rp0, 0);
    chk("rov_free", fc0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dsp_tag_alloc.md
Name: dsp_tag_alloc

Overview:
- Parametrised circular tag allocator for the dispatch stage. It hands out in-order IDs (ROB, load-buffer or store-buffer) to up to LANES instructions per cycle.
- IDs are reclaimed from up to RET_LANES retiring instructions per cycle.
- Recovery: the dispatch pointer rolls back on a trap flush, or on the older of two partial flush sources.
- One instance per ID space replaces the fixed 4-wide, fixed-width per-queue generators with a single configurable block.

Parameters:
- DEPTH, 128: number of entries; power of 2, at least 4.
- LANES, 4: dispatch request lanes.
- RET_LANES, 4: retire lanes.
- FLUSH_KEEP, 1: 1 = the flushing ID survives (dispatch pointer restarts at flush_id+1); 0 = the flushing ID is discarded (restarts at flush_id).
- IDW, log2(DEPTH)+1: ID width; the MSB is the wrap (lap) bit. Derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_flush_trap  in  1  full flush; discards all non-retired IDs.
- i_flush_a_vld  in  1  partial flush source A (branch mispredict).
- i_flush_a_id  in  IDW  ID of flushing instruction A.
- i_flush_b_vld  in  1  partial flush source B (load/store ordering).
- i_flush_b_id  in  IDW  ID of flushing instruction B.
- i_stall  in  1  downstream stall; blocks allocation.
- i_req_vld  in  LANES  per-lane allocation request; may be sparse.
- o_grant  out  1  allocation accepted this cycle.
- o_id  out  LANES*IDW  packed IDs; lane k occupies bits [k*IDW +: IDW].
- o_dsp_ptr  out  IDW  next ID to allocate.
- o_ret_ptr  out  IDW  oldest non-retired ID.
- i_ret_vld  in  RET_LANES  retire lanes; must be thermometer-coded from bit 0.
- o_free_cnt  out  IDW  free entries, range 0..DEPTH.
- o_list_empty  out  1  no free entries (o_free_cnt==0).

Behaviour:
- Reset (rst=1 at a clk edge): dsp_ptr=0, ret_ptr=0. Resulting outputs: o_free_cnt=DEPTH, o_list_empty=0, o_grant=0, o_id lanes = 0,1,2,...
  - Reset asserted mid-operation overrides flush, retire and allocation in that cycle.
- Pointer arithmetic: all pointer arithmetic is modulo 2*DEPTH on IDW bits.
  - occ = dsp_ptr - ret_ptr.
  - free = DEPTH - occ.
  - DEPTH entries in flight: dsp_ptr and ret_ptr have equal low bits and differing wrap bits.
- o_id is combinational from dsp_ptr and i_req_vld.
  - Lane k ID = dsp_ptr + popcount(i_req_vld[k-1:0]); IDs are compacted over valid lanes.
  - Values on invalid lanes are don't-care.
- Grant rule: o_grant = |i_req_vld & ~i_stall & ~any_flush & (free >= popcount(i_req_vld)).
  - Allocation is all-or-nothing; there is no partial grant.
  - On grant, next dsp_ptr = dsp_ptr + popcount(i_req_vld).
- Retire: next ret_ptr = ret_ptr + popcount(i_ret_vld), every cycle, independent of stall.
  - Retire is also applied during a flush.
  - Non-thermometer i_ret_vld, or retire count > occ, is illegal; a simulation assertion fires.
- Age compare, older(a,b):
  - Wrap bits equal: older = (a[IDW-2:0] < b[IDW-2:0]).
  - Wrap bits differ: older = (a[IDW-2:0] >= b[IDW-2:0]).
- Flush priority, evaluated in the same cycle, highest first:
  1. rst.
  2. i_flush_trap: next dsp_ptr = next ret_ptr (post-retire); occupancy becomes 0.
  3. Partial flush: selected ID = older of A and B when both are valid, else whichever is valid. Next dsp_ptr = sel_id + FLUSH_KEEP.
  4. Normal allocation.
- A flush in any form suppresses o_grant in that cycle; allocation resumes the next cycle.
- A partial flush ID must lie within [ret_ptr, dsp_ptr); out-of-window IDs are illegal (assertion).
- Latency:
  - Grant and IDs are visible in the same cycle.
  - Pointer and o_free_cnt updates are visible the cycle after the event.
- Full/empty boundaries:
  - With o_free_cnt=0: o_list_empty=1 and any request is refused.
  - With retire and allocation in the same cycle, grant uses the current (pre-retire) free count. Freed entries are usable next cycle.
- Wrap-around: pointers wrap from 2*DEPTH-1 to 0 naturally; no special state.

Test Plan:
- Reset, DEPTH=8/LANES=4 (IDW=4): assert rst 2 cycles -> dsp_ptr=0, ret_ptr=0, free=8, list_empty=0, grant=0. Then req=4'b1111 -> ids 0,1,2,3.
- Sparse request, from reset: req=4'b1011, stall=0 -> lane0=0, lane1=1, lane3=2, grant=1. Next cycle dsp_ptr=3, free=5. Repeat with stall=1 -> grant=0, dsp_ptr stays 3.
- Full: allocate 8 IDs with no retire -> dsp_ptr=4'b1000, free=0, list_empty=1; req=4'b0001 -> grant=0. Then ret_vld=4'b0011 -> next ret_ptr=2, free=2, list_empty=0.
- Dual flush, same lap: ret_ptr=0, dsp_ptr=7, a_id=5, b_id=3, FLUSH_KEEP=1, req active -> grant=0, next dsp_ptr=4. With FLUSH_KEEP=0 -> next dsp_ptr=3.
- Dual flush across wrap: ret_ptr=6, dsp_ptr=4'b1010, a_id=4'b1001, b_id=4'b0111 -> B selected as older, next dsp_ptr=4'b1000.
- Trap with concurrent retire: ret_ptr=2, dsp_ptr=6, ret_vld=4'b0011, trap=1, req=4'b1111 -> grant=0. Next ret_ptr=4, dsp_ptr=4, free=8.
